rram_instr_sequencer: RTL and testbench
=======================================

Name: rram_instr_sequencer

Overview:
- Issue-side counterpart of the RRAM instruction decoder: turns host command requests into the 32-bit instruction stream the decoder consumes.
- Accepts one command at a time over a valid/ready handshake and formats the instruction word.
- Holds each word on the bus for a programmable number of cycles, then inserts NOP gap cycles.
- Splits wide MAC row ranges into chunks the array can enable at once.
- Sits between the host/controller FSM and the decoder's instruction input.

Parameters:
- INSTRUCTION_SIZE, 32, instruction width; the field layout below requires 32.
- NUM_WL_ENABLE_MAC_OPS, 4, maximum rows per issued MAC instruction.
- WR_HOLD, 2, cycles a WRITE word is held (1..255).
- RD_HOLD, 2, cycles a READ word is held (1..255); covers the decoder's posedge plus negedge read phases.
- CFG_HOLD, 1, cycles a MAC, CONF_T or CONF_V word is held (1..255).
- GAP_CYCLES, 1, NOP cycles after each issued word (0..255).
- OP_NOP / OP_WRITE / OP_READ / OP_MAC / OP_CONF_T / OP_CONF_V, 4'h0 / 4'h1 / 4'h2 / 4'h3 / 4'h4 / 4'h5, opcode values placed in bits [31:28].

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  3  0=WRITE, 1=READ, 2=MAC, 3=CONF_T, 4=CONF_V, 5..7 illegal
- cmd_col  in  4  column, or MAC column start
- cmd_row  in  4  row, or MAC row start
- cmd_col_end  in  4  MAC column end
- cmd_row_end  in  4  MAC row end
- cmd_t_type  in  2  T-pulse op type
- cmd_t_mult  in  8  T-pulse multiplier
- cmd_v_type  in  2  V-pulse op type
- cmd_v_sel  in  2  V-pulse mux select
- instruction  out  32  word to the decoder (registered)
- busy  out  1  command in progress
- done  out  1  one-cycle pulse when a command fully completes
- err  out  1  one-cycle pulse when a command is rejected

Behaviour:
- Reset (async, rst=0):
  - state=IDLE, instruction=32'h0 (NOP), cmd_ready=1, busy=0, done=0, err=0.
  - All counters and captured fields = 0.
  - Reset asserted mid-command abandons the command with no done; NOP is driven immediately.
- Word formats; all bits not listed are 0:
  - WRITE/READ: [7:4]=row, [3:0]=col.
  - MAC: [15:12]=col_start, [11:8]=col_end, [7:4]=row_start, [3:0]=row_end.
  - CONF_T: [9:8]=type, [7:0]=mult.
  - CONF_V: [3:2]=type, [1:0]=sel.
- Handshake:
  - Accept occurs when cmd_valid && cmd_ready. cmd_ready = (state==IDLE), so the sequencer takes at most one command per idle cycle.
  - All cmd_* fields are captured on accept.
- Command checks at accept, in IDLE:
  - Reject if cmd_op>4, or if op is MAC and (col_end<col_start or row_end<row_start).
  - On reject: err=1 for the next cycle, state stays IDLE, instruction stays NOP.
- FSM states: IDLE, HOLD, GAP.
- IDLE -> HOLD on a legal accept:
  - Next cycle, instruction = the formatted word; hold counter loads (hold parameter - 1).
- HOLD:
  - Word is held constant; counter decrements each cycle.
  - When counter==0: if GAP_CYCLES>0, go to GAP with instruction=NOP and the gap counter loaded with GAP_CYCLES-1; otherwise go straight to the completion check.
- GAP:
  - NOP is driven; counter decrements; at 0, run the completion check.
- Completion check (MAC only continues):
  - If cur_row_end < row_end, set next row_start = cur_row_end+1 and re-enter HOLD with the next chunk word.
  - Otherwise go to IDLE with done=1 for one cycle.
- MAC chunking:
  - cur_row_end = min(row_start+NUM_WL_ENABLE_MAC_OPS-1, row_end).
  - The sum is computed 5 bits wide so row 15 cannot wrap.
  - Column fields are unchanged across chunks.
- Timing:
  - Latency from accept to first word on instruction = 1 cycle.
  - Total cycles per word = hold + GAP_CYCLES.
  - done asserts in the cycle state returns to IDLE; cmd_ready=1 in that same cycle, so back-to-back commands are allowed.
- busy = (state != IDLE).
- done and err are never asserted together.

Test Plan:
- Reset then idle: rst=0 mid-HOLD of a WRITE -> instruction=32'h0 immediately, cmd_ready=1, busy=0, no done.
- WRITE col=5 row=9 (WR_HOLD=2, GAP=1) -> instruction=32'h1000_0095 for exactly 2 cycles, then 32'h0 for 1 cycle, then done pulse.
- READ col=12 row=3 (RD_HOLD=2) -> instruction=32'h2000_003C for 2 cycles, NOP 1 cycle, done; cmd_ready low throughout.
- MAC col 2..10, row 1..10 (N=4) -> three words with 1-cycle NOP gaps and one done after the last:
  - 32'h3000_2A14
  - 32'h3000_2A58
  - 32'h3000_2A9A
- MAC row 15..15 -> single word 32'h3000_xxFF with correct columns; no wrap, one done.
- Illegal: cmd_op=6, or MAC with row_end=2 < row_start=7 -> err pulse 1 cycle, no non-NOP word, busy stays 0.
- CONF_T type=2 mult=8'hA5 immediately followed by CONF_V type=1 sel=3 -> 32'h4000_02A5 then, after its gap, 32'h5000_0007; two done pulses.

Source files
------------

// File: rtl/rram_instr_sequencer.sv
`timescale 1ns/1ps
// rram_instr_sequencer
//   Issue-side companion of the RRAM instruction decoder. Accepts one host
//   command at a time over cmd_valid/cmd_ready. It formats the 32-bit
//   instruction word and holds it on the bus for a per-opcode number of
//   cycles. After each word it inserts NOP gap cycles. Wide MAC row ranges
//   are split into chunks of at most NUM_WL_ENABLE_MAC_OPS rows.
//
// Ports
//   clk          clock
//   rst          asynchronous active-low reset
//   cmd_valid    command request
//   cmd_ready    high in IDLE; a command is accepted on valid && ready
//   cmd_op       0=WRITE 1=READ 2=MAC 3=CONF_T 4=CONF_V (5..7 rejected)
//   cmd_col      column / MAC column start
//   cmd_row      row / MAC row start
//   cmd_col_end  MAC column end
//   cmd_row_end  MAC row end
//   cmd_t_type   T-pulse op type
//   cmd_t_mult   T-pulse multiplier
//   cmd_v_type   V-pulse op type
//   cmd_v_sel    V-pulse mux select
//   instruction  registered word to the decoder (NOP = all zero)
//   busy         command in progress
//   done         one-cycle pulse when a command completes
//   err          one-cycle pulse when a command is rejected
module rram_instr_sequencer #(
  parameter int unsigned INSTRUCTION_SIZE      = 32,
  parameter int unsigned NUM_WL_ENABLE_MAC_OPS = 4,
  parameter int unsigned WR_HOLD               = 2,
  parameter int unsigned RD_HOLD               = 2,
  parameter int unsigned CFG_HOLD              = 1,
  parameter int unsigned GAP_CYCLES            = 1,
  parameter logic [3:0]  OP_NOP                = 4'h0,
  parameter logic [3:0]  OP_WRITE              = 4'h1,
  parameter logic [3:0]  OP_READ               = 4'h2,
  parameter logic [3:0]  OP_MAC                = 4'h3,
  parameter logic [3:0]  OP_CONF_T             = 4'h4,
  parameter logic [3:0]  OP_CONF_V             = 4'h5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [2:0]                  cmd_op,
  input  logic [3:0]                  cmd_col,
  input  logic [3:0]                  cmd_row,
  input  logic [3:0]                  cmd_col_end,
  input  logic [3:0]                  cmd_row_end,
  input  logic [1:0]                  cmd_t_type,
  input  logic [7:0]                  cmd_t_mult,
  input  logic [1:0]                  cmd_v_type,
  input  logic [1:0]                  cmd_v_sel,
  output logic [INSTRUCTION_SIZE-1:0] instruction,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_t;

  state_t                      r_state, w_nxt_state;
  logic [INSTRUCTION_SIZE-1:0] r_instr, w_nxt_instr;
  logic [7:0]                  r_cnt, w_nxt_cnt;
  logic                        r_done, w_nxt_done;
  logic                        r_err, w_nxt_err;
  logic [2:0]                  r_op, w_nxt_op;
  logic [3:0]                  r_col, w_nxt_col;
  logic [3:0]                  r_row, w_nxt_row;
  logic [3:0]                  r_col_end, w_nxt_col_end;
  logic [3:0]                  r_row_end, w_nxt_row_end;
  logic [1:0]                  r_t_type, w_nxt_t_type;
  logic [7:0]                  r_t_mult, w_nxt_t_mult;
  logic [1:0]                  r_v_type, w_nxt_v_type;
  logic [1:0]                  r_v_sel, w_nxt_v_sel;

  logic       w_illegal;
  logic       w_complete;
  logic [3:0] w_cur_end;
  logic [3:0] w_next_start;

  // Last row of the chunk starting at rs; the 5-bit sum keeps row 15 from wrapping.
  function automatic logic [3:0] chunk_end(input logic [3:0] rs, input logic [3:0] re);
    logic [4:0] sum;
    sum = {1'b0, rs} + 5'(NUM_WL_ENABLE_MAC_OPS - 1);
    if (sum > {1'b0, re}) return re;
    else                  return sum[3:0];
  endfunction

  function automatic logic [7:0] hold_load(input logic [2:0] op);
    case (op)
      3'd0:    return 8'(WR_HOLD - 1);
      3'd1:    return 8'(RD_HOLD - 1);
      default: return 8'(CFG_HOLD - 1);
    endcase
  endfunction

  function automatic logic [INSTRUCTION_SIZE-1:0] fmt(
    input logic [2:0] op,
    input logic [3:0] col,
    input logic [3:0] row,
    input logic [3:0] col_end,
    input logic [3:0] row_end,
    input logic [1:0] t_type,
    input logic [7:0] t_mult,
    input logic [1:0] v_type,
    input logic [1:0] v_sel
  );
    logic [INSTRUCTION_SIZE-1:0] w;
    w = '0;
    case (op)
      3'd0: begin w[31:28] = OP_WRITE;  w[7:4] = row; w[3:0] = col; end
      3'd1: begin w[31:28] = OP_READ;   w[7:4] = row; w[3:0] = col; end
      3'd2: begin
        w[31:28] = OP_MAC;
        w[15:12] = col;
        w[11:8]  = col_end;
        w[7:4]   = row;
        w[3:0]   = row_end;
      end
      3'd3: begin w[31:28] = OP_CONF_T; w[9:8] = t_type; w[7:0] = t_mult; end
      3'd4: begin w[31:28] = OP_CONF_V; w[3:2] = v_type; w[1:0] = v_sel; end
      default: w[31:28] = OP_NOP;
    endcase
    return w;
  endfunction

  assign w_illegal    = (cmd_op > 3'd4) ||
                        ((cmd_op == 3'd2) && ((cmd_col_end < cmd_col) || (cmd_row_end < cmd_row)));
  assign w_cur_end    = chunk_end(r_row, r_row_end);
  assign w_next_start = w_cur_end + 4'd1;

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_instr   = r_instr;
    w_nxt_cnt     = r_cnt;
    w_nxt_done    = 1'b0;
    w_nxt_err     = 1'b0;
    w_nxt_op      = r_op;
    w_nxt_col     = r_col;
    w_nxt_row     = r_row;
    w_nxt_col_end = r_col_end;
    w_nxt_row_end = r_row_end;
    w_nxt_t_type  = r_t_type;
    w_nxt_t_mult  = r_t_mult;
    w_nxt_v_type  = r_v_type;
    w_nxt_v_sel   = r_v_sel;
    w_complete    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_nxt_op      = cmd_op;
          w_nxt_col     = cmd_col;
          w_nxt_row     = cmd_row;
          w_nxt_col_end = cmd_col_end;
          w_nxt_row_end = cmd_row_end;
          w_nxt_t_type  = cmd_t_type;
          w_nxt_t_mult  = cmd_t_mult;
          w_nxt_v_type  = cmd_v_type;
          w_nxt_v_sel   = cmd_v_sel;
          if (w_illegal) begin
            w_nxt_err = 1'b1;
          end else begin
            w_nxt_state = S_HOLD;
            w_nxt_cnt   = hold_load(cmd_op);
            w_nxt_instr = fmt(cmd_op, cmd_col, cmd_row, cmd_col_end,
                              chunk_end(cmd_row, cmd_row_end),
                              cmd_t_type, cmd_t_mult, cmd_v_type, cmd_v_sel);
          end
        end
      end
      S_HOLD: begin
        if (r_cnt != 8'd0) begin
          w_nxt_cnt = r_cnt - 8'd1;
        end else if (GAP_CYCLES > 0) begin
          w_nxt_state = S_GAP;
          w_nxt_cnt   = 8'(GAP_CYCLES - 1);
          w_nxt_instr = '0;
        end else begin
          w_complete = 1'b1;
        end
      end
      S_GAP: begin
        if (r_cnt != 8'd0) w_nxt_cnt = r_cnt - 8'd1;
        else               w_complete = 1'b1;
      end
      default: w_nxt_state = S_IDLE;
    endcase

    // Shared end-of-word step for HOLD (no gap) and GAP: next MAC chunk or finish.
    if (w_complete) begin
      if ((r_op == 3'd2) && (w_cur_end < r_row_end)) begin
        w_nxt_state = S_HOLD;
        w_nxt_row   = w_next_start;
        w_nxt_cnt   = hold_load(r_op);
        w_nxt_instr = fmt(r_op, r_col, w_next_start, r_col_end,
                          chunk_end(w_next_start, r_row_end),
                          r_t_type, r_t_mult, r_v_type, r_v_sel);
      end else begin
        w_nxt_state = S_IDLE;
        w_nxt_instr = '0;
        w_nxt_done  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_instr   <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_op      <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_col_end <= '0;
      r_row_end <= '0;
      r_t_type  <= '0;
      r_t_mult  <= '0;
      r_v_type  <= '0;
      r_v_sel   <= '0;
    end else begin
      r_state   <= w_nxt_state;
      r_instr   <= w_nxt_instr;
      r_cnt     <= w_nxt_cnt;
      r_done    <= w_nxt_done;
      r_err     <= w_nxt_err;
      r_op      <= w_nxt_op;
      r_col     <= w_nxt_col;
      r_row     <= w_nxt_row;
      r_col_end <= w_nxt_col_end;
      r_row_end <= w_nxt_row_end;
      r_t_type  <= w_nxt_t_type;
      r_t_mult  <= w_nxt_t_mult;
      r_v_type  <= w_nxt_v_type;
      r_v_sel   <= w_nxt_v_sel;
    end
  end

  assign instruction = r_instr;
  assign cmd_ready   = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign err         = r_err;

endmodule

// File: tb/tb_rram_instr_sequencer.sv
`timescale 1ns/1ps
module tb_rram_instr_sequencer;

  localparam int WRH = 2;
  localparam int RDH = 2;
  localparam int CFH = 1;
  localparam int GAP = 1;
  localparam int NWL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_col, cmd_row, cmd_col_end, cmd_row_end;
  logic [1:0]  cmd_t_type, cmd_v_type, cmd_v_sel;
  logic [7:0]  cmd_t_mult;
  logic [31:0] instruction;
  logic        busy, done, err;

  always #5 clk = ~clk;

  rram_instr_sequencer #(
    .INSTRUCTION_SIZE(32), .NUM_WL_ENABLE_MAC_OPS(NWL),
    .WR_HOLD(WRH), .RD_HOLD(RDH), .CFG_HOLD(CFH), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_col(cmd_col), .cmd_row(cmd_row),
    .cmd_col_end(cmd_col_end), .cmd_row_end(cmd_row_end),
    .cmd_t_type(cmd_t_type), .cmd_t_mult(cmd_t_mult),
    .cmd_v_type(cmd_v_type), .cmd_v_sel(cmd_v_sel),
    .instruction(instruction), .busy(busy), .done(done), .err(err)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic        busy;
    logic        done;
    logic        err;
  } cyc_t;

  cyc_t exp_q[$];

  function automatic void push(input logic [31:0] w, input logic b, input logic d, input logic e);
    cyc_t c;
    c.instr = w; c.busy = b; c.done = d; c.err = e;
    exp_q.push_back(c);
  endfunction

  function automatic void push_word(input logic [31:0] w, input int hold);
    for (int i = 0; i < hold; i++) push(w, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < GAP; i++)  push(32'h0, 1'b1, 1'b0, 1'b0);
  endfunction

  // Expected per-cycle outputs, starting with the cycle after the accept edge.
  function automatic void model(input int op, input int col, input int row, input int ce,
                                input int re, input int tt, input int tm, input int vt, input int vs);
    exp_q.delete();
    if (op > 4 || (op == 2 && (ce < col || re < row))) begin
      push(32'h0, 1'b0, 1'b0, 1'b1);
      return;
    end
    case (op)
      0: push_word(32'(32'h1000_0000 + row * 16 + col), WRH);
      1: push_word(32'(32'h2000_0000 + row * 16 + col), RDH);
      2: begin
        for (int s = row; s <= re; s += NWL) begin
          int e;
          e = (s + NWL - 1 < re) ? s + NWL - 1 : re;
          push_word(32'(32'h3000_0000 + col * 4096 + ce * 256 + s * 16 + e), CFH);
        end
      end
      3: push_word(32'(32'h4000_0000 + tt * 256 + tm), CFH);
      default: push_word(32'(32'h5000_0000 + vt * 4 + vs), CFH);
    endcase
    push(32'h0, 1'b0, 1'b1, 1'b0);
  endfunction

  // Entered with the DUT idle (possibly in a done/err cycle) shortly after a posedge;
  // returns #1 after the posedge of the final expected cycle.
  task automatic run_cmd(input int op, input int col, input int row, input int ce, input int re,
                         input int tt, input int tm, input int vt, input int vs, input string tag);
    cmd_valid   = 1'b1;
    cmd_op      = op[2:0];
    cmd_col     = col[3:0];
    cmd_row     = row[3:0];
    cmd_col_end = ce[3:0];
    cmd_row_end = re[3:0];
    cmd_t_type  = tt[1:0];
    cmd_t_mult  = tm[7:0];
    cmd_v_type  = vt[1:0];
    cmd_v_sel   = vs[1:0];
    model(op, col, row, ce, re, tt, tm, vt, vs);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    foreach (exp_q[i]) begin
      if (i > 0) begin @(posedge clk); #1; end
      check({tag, ".instr"}, instruction, exp_q[i].instr);
      check({tag, ".busy"},  32'(busy),      32'(exp_q[i].busy));
      check({tag, ".ready"}, 32'(cmd_ready), 32'(!exp_q[i].busy));
      check({tag, ".done"},  32'(done),      32'(exp_q[i].done));
      check({tag, ".err"},   32'(err),       32'(exp_q[i].err));
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("idle.instr", instruction, 32'h0);
      check("idle.busy",  32'(busy), 32'h0);
      check("idle.flags", 32'({done, err}), 32'h0);
    end
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_col = '0; cmd_row = '0;
    cmd_col_end = '0; cmd_row_end = '0; cmd_t_type = '0; cmd_t_mult = '0;
    cmd_v_type = '0; cmd_v_sel = '0;
    #2;
    check("rst.instr", instruction, 32'h0);
    check("rst.ready", 32'(cmd_ready), 32'h1);
    check("rst.busy",  32'(busy), 32'h0);
    check("rst.flags", 32'({done, err}), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle_cycles(2);

    // Reset in the middle of a WRITE hold.
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_col = 4'd5; cmd_row = 4'd9;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("mid.instr", instruction, 32'h1000_0095);
    check("mid.busy",  32'(busy), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst.instr", instruction, 32'h0);
    check("mid_rst.ready", 32'(cmd_ready), 32'h1);
    check("mid_rst.busy",  32'(busy), 32'h0);
    check("mid_rst.done",  32'(done), 32'h0);
    @(negedge clk); rst = 1'b1;
    idle_cycles(3);

    // Directed vectors, back to back.
    run_cmd(0, 5, 9, 0, 0, 0, 0, 0, 0, "write");
    run_cmd(1, 12, 3, 0, 0, 0, 0, 0, 0, "read");
    run_cmd(2, 2, 1, 10, 10, 0, 0, 0, 0, "mac3");
    run_cmd(2, 3, 15, 7, 15, 0, 0, 0, 0, "mac15");
    run_cmd(6, 1, 1, 1, 1, 0, 0, 0, 0, "ill_op");
    run_cmd(2, 0, 7, 4, 2, 0, 0, 0, 0, "ill_mac");
    run_cmd(3, 0, 0, 0, 0, 2, 8'hA5, 0, 0, "conf_t");
    run_cmd(4, 0, 0, 0, 0, 0, 0, 1, 3, "conf_v");
    run_cmd(2, 0, 12, 15, 15, 0, 0, 0, 0, "mac_top");
    idle_cycles(1);

    // Randomised commands with occasional idle gaps.
    for (int k = 0; k < 200; k++) begin
      int op, c, r, ce, re, t;
      op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
      c  = $urandom_range(0, 15); r  = $urandom_range(0, 15);
      ce = $urandom_range(0, 15); re = $urandom_range(0, 15);
      if ($urandom_range(0, 3) != 0) begin
        if (ce < c) begin t = c; c = ce; ce = t; end
        if (re < r) begin t = r; r = re; re = t; end
      end
      run_cmd(op, c, r, ce, re, $urandom_range(0, 3), $urandom_range(0, 255),
              $urandom_range(0, 3), $urandom_range(0, 3), "rand");
      if ($urandom_range(0, 4) == 0) idle_cycles($urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
